// File: rtl/sobel_grad_if.sv
// Pixel-stream and gradient-result bundle for the sobel_grad block.
// slave = the gradient engine, master = whatever feeds it pixels.
interface sobel_grad_if #(
   parameter int PIXW = 24
);
   logic                   startEn;
   logic [7:0]             pixIn;
   logic                   pixValid;
   logic signed [8:0]      sobelX;
   logic signed [8:0]      sobelY;
   logic                   outValid;
   logic [PIXW-1:0]        centreAddr;
   logic                   frameDone;

   modport master (
      output startEn, pixIn, pixValid,
      input  sobelX, sobelY, outValid, centreAddr, frameDone
   );

   modport slave (
      input  startEn, pixIn, pixValid,
      output sobelX, sobelY, outValid, centreAddr, frameDone
   );
endinterface

// File: rtl/sobel_grad.sv
// Streaming 3x3 Sobel gradient engine: two line buffers feed a 3x3 window,
// gradients are registered one cycle later and presented on the next.
//
// state  | meaning
// IDLE   | waiting for startEn; pixels ignored
// RUN    | accepting raster pixels on pixValid
// DONE   | last pixel taken; returns to IDLE next cycle
module sobel_grad #(
   parameter int IMGW = 1024,
   parameter int IMGH = 512,
   parameter int PIXW = 24
) (
   input  logic            clk,
   input  logic            reset,
   sobel_grad_if.slave     bus
);
   localparam int CW = $clog2(IMGW);
   localparam int RW = $clog2(IMGH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [CW-1:0]         col_q, col_d;
   logic [RW-1:0]         row_q, row_d;
   logic [PIXW-1:0]       addr_q, addr_d;

   logic [7:0]            win_q [3][3];
   logic [7:0]            win_d [3][3];
   logic                  win_vld_q, win_vld_d;
   logic                  win_last_q, win_last_d;
   logic [PIXW-1:0]       win_addr_q, win_addr_d;

   logic signed [10:0]    gx_q, gx_d;
   logic signed [10:0]    gy_q, gy_d;
   logic                  g_vld_q, g_vld_d;
   logic                  g_last_q, g_last_d;
   logic [PIXW-1:0]       g_addr_q, g_addr_d;

   logic signed [8:0]     sx_q, sx_d;
   logic signed [8:0]     sy_q, sy_d;
   logic [PIXW-1:0]       ca_q, ca_d;
   logic                  ov_q, ov_d;
   logic                  ol_q, ol_d;
   logic                  fd_q, fd_d;

   logic [7:0]            lb1_q [IMGW];
   logic [7:0]            lb2_q [IMGW];

   logic                  accept;
   logic                  col_end;
   logic                  row_end;
   logic [7:0]            lb_top;
   logic [7:0]            lb_mid;
   logic [10:0]           gx_pos, gx_neg, gy_pos, gy_neg;

   assign accept  = (state_q == S_RUN) && bus.pixValid;
   assign col_end = (col_q == CW'(IMGW - 1));
   assign row_end = (row_q == RW'(IMGH - 1));
   assign lb_top  = lb2_q[col_q];
   assign lb_mid  = lb1_q[col_q];

   // Control: frame FSM plus raster counters
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      addr_d  = addr_q;
      case (state_q)
         S_IDLE: begin
            if (bus.startEn) begin
               state_d = S_RUN;
               col_d   = '0;
               row_d   = '0;
               addr_d  = '0;
            end
         end
         S_RUN: begin
            if (accept) begin
               addr_d = addr_q + PIXW'(1);
               if (col_end) begin
                  col_d = '0;
                  row_d = row_q + RW'(1);
                  if (row_end) begin
                     state_d = S_DONE;
                  end
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Window: shift left on each accepted pixel, new column enters at j=2.
   // Stale columns left over from the previous row are flushed out by
   // cols 0..1 before the window is first used at col 2.
   always_comb begin
      win_d      = win_q;
      win_vld_d  = 1'b0;
      win_last_d = 1'b0;
      win_addr_d = win_addr_q;
      if (accept) begin
         for (int i = 0; i < 3; i++) begin
            win_d[i][0] = win_q[i][1];
            win_d[i][1] = win_q[i][2];
         end
         win_d[0][2] = lb_top;
         win_d[1][2] = lb_mid;
         win_d[2][2] = bus.pixIn;
         win_vld_d   = (row_q >= RW'(2)) && (col_q >= CW'(2));
         win_last_d  = col_end && row_end;
         win_addr_d  = addr_q - PIXW'(IMGW) - PIXW'(1);
      end
   end

   // Gradient stage: sums are non-negative and below 2048, so the
   // 11-bit difference wraps to the correct signed value.
   always_comb begin
      gx_pos = {3'b000, win_q[0][2]} + {2'b00, win_q[1][2], 1'b0} + {3'b000, win_q[2][2]};
      gx_neg = {3'b000, win_q[0][0]} + {2'b00, win_q[1][0], 1'b0} + {3'b000, win_q[2][0]};
      gy_pos = {3'b000, win_q[2][0]} + {2'b00, win_q[2][1], 1'b0} + {3'b000, win_q[2][2]};
      gy_neg = {3'b000, win_q[0][0]} + {2'b00, win_q[0][1], 1'b0} + {3'b000, win_q[0][2]};
      gx_d     = gx_q;
      gy_d     = gy_q;
      g_addr_d = g_addr_q;
      g_vld_d  = win_vld_q;
      g_last_d = win_vld_q && win_last_q;
      if (win_vld_q) begin
         gx_d     = $signed(gx_pos - gx_neg);
         gy_d     = $signed(gy_pos - gy_neg);
         g_addr_d = win_addr_q;
      end
   end

   // Output stage: bits [10:2] are the floor of G/4; results hold otherwise
   always_comb begin
      sx_d = sx_q;
      sy_d = sy_q;
      ca_d = ca_q;
      ov_d = g_vld_q;
      ol_d = g_vld_q && g_last_q;
      fd_d = ol_q;
      if (g_vld_q) begin
         sx_d = gx_q[10:2];
         sy_d = gy_q[10:2];
         ca_d = g_addr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         col_q      <= '0;
         row_q      <= '0;
         addr_q     <= '0;
         for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
               win_q[i][j] <= '0;
            end
         end
         win_vld_q  <= 1'b0;
         win_last_q <= 1'b0;
         win_addr_q <= '0;
         gx_q       <= '0;
         gy_q       <= '0;
         g_vld_q    <= 1'b0;
         g_last_q   <= 1'b0;
         g_addr_q   <= '0;
         sx_q       <= '0;
         sy_q       <= '0;
         ca_q       <= '0;
         ov_q       <= 1'b0;
         ol_q       <= 1'b0;
         fd_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         row_q      <= row_d;
         addr_q     <= addr_d;
         win_q      <= win_d;
         win_vld_q  <= win_vld_d;
         win_last_q <= win_last_d;
         win_addr_q <= win_addr_d;
         gx_q       <= gx_d;
         gy_q       <= gy_d;
         g_vld_q    <= g_vld_d;
         g_last_q   <= g_last_d;
         g_addr_q   <= g_addr_d;
         sx_q       <= sx_d;
         sy_q       <= sy_d;
         ca_q       <= ca_d;
         ov_q       <= ov_d;
         ol_q       <= ol_d;
         fd_q       <= fd_d;
      end
   end

   // Line buffers: lb1 holds row r-1, lb2 row r-2; contents survive reset
   always_ff @(posedge clk) begin
      if (!reset && accept) begin
         lb2_q[col_q] <= lb1_q[col_q];
         lb1_q[col_q] <= bus.pixIn;
      end
   end

   assign bus.sobelX     = sx_q;
   assign bus.sobelY     = sy_q;
   assign bus.centreAddr = ca_q;
   assign bus.outValid   = ov_q;
   assign bus.frameDone  = fd_q;

endmodule

// File: tb/tb_sobel_grad.sv
// Self-checking bench for sobel_grad on an 8x6 image: expected gradients come
// from the Sobel formula applied to a stored image, scheduled 2 edges after acceptance.
module tb_sobel_grad;
   localparam int W    = 8;
   localparam int H    = 6;
   localparam int PW   = 24;
   localparam int MAXC = 4096;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sobel_grad_if #(.PIXW(PW)) bus ();

   sobel_grad #(.IMGW(W), .IMGH(H), .PIXW(PW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int                img [H][W];
   logic              exp_v  [MAXC];
   logic              exp_fd [MAXC];
   logic signed [8:0] exp_x  [MAXC];
   logic signed [8:0] exp_y  [MAXC];
   logic [PW-1:0]     exp_a  [MAXC];
   logic signed [8:0] held_x, held_y;
   logic [PW-1:0]     held_a;
   int ec, n_cmp, n_err;
   int obs_outs, obs_fd, obs_x255, obs_y255;

   function automatic int pix(input int r, input int c);
      return img[r][c];
   endfunction

   function automatic int grad_x(input int r, input int c);
      return (pix(r-1,c+1) + 2*pix(r,c+1) + pix(r+1,c+1))
           - (pix(r-1,c-1) + 2*pix(r,c-1) + pix(r+1,c-1));
   endfunction

   function automatic int grad_y(input int r, input int c);
      return (pix(r+1,c-1) + 2*pix(r+1,c) + pix(r+1,c+1))
           - (pix(r-1,c-1) + 2*pix(r-1,c) + pix(r-1,c+1));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
      n_cmp++;
      assert (obs === exp_val) else begin
         n_err++;
         $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, ec, obs, exp_val);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      ec++;
      if (ec >= MAXC - 8) begin
         $display("FAIL cycle_budget edge=%0d observed=over expected=under %0d", ec, MAXC - 8);
         $fatal(1, "cycle budget exhausted");
      end
      if (reset) begin
         for (int k = ec; k < MAXC; k++) begin
            exp_v[k]  = 1'b0;
            exp_fd[k] = 1'b0;
         end
         held_x = '0;
         held_y = '0;
         held_a = '0;
      end else if (exp_v[ec]) begin
         held_x = exp_x[ec];
         held_y = exp_y[ec];
         held_a = exp_a[ec];
      end
      chk("outValid",   32'(bus.outValid),   32'(exp_v[ec]));
      chk("frameDone",  32'(bus.frameDone),  32'(exp_fd[ec]));
      chk("sobelX",     32'(bus.sobelX),     32'(held_x));
      chk("sobelY",     32'(bus.sobelY),     32'(held_y));
      chk("centreAddr", 32'(bus.centreAddr), 32'(held_a));
      if (bus.outValid) begin
         obs_outs++;
         if (bus.sobelX == 9'sd255) obs_x255++;
         if (bus.sobelY == 9'sd255) obs_y255++;
      end
      if (bus.frameDone) obs_fd++;
   endtask

   // mode: 0 flat(val), 1 vertical edge, 2 horizontal edge, 3 random, 4 keep image
   task automatic run_frame(input int mode, input int val, input int gap_pct,
                            input int abort_idx, input bit noise);
      int  n, r, c;
      bit  v, aborted;
      for (int i = 0; i < H; i++) begin
         for (int j = 0; j < W; j++) begin
            case (mode)
               0: img[i][j] = val;
               1: img[i][j] = (j >= 4) ? 255 : 0;
               2: img[i][j] = (i >= 3) ? 255 : 0;
               3: img[i][j] = int'($urandom_range(255));
               default: ;
            endcase
         end
      end
      obs_outs = 0; obs_fd = 0; obs_x255 = 0; obs_y255 = 0;
      if (noise) begin
         for (int k = 0; k < 3; k++) begin
            bus.pixValid = 1'b1;
            bus.pixIn    = 8'($urandom_range(255));
            tick();
         end
      end
      bus.startEn  = 1'b1;
      bus.pixValid = 1'b0;
      tick();
      bus.startEn = 1'b0;
      n = 0;
      aborted = 1'b0;
      while (n < W*H && !aborted) begin
         r = n / W;
         c = n % W;
         v = (int'($urandom_range(99)) >= gap_pct) || (n == abort_idx);
         bus.pixValid = v;
         bus.pixIn    = v ? 8'(img[r][c]) : 8'($urandom_range(255));
         bus.startEn  = noise && ($urandom_range(4) == 0);
         if (v && n == abort_idx) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            aborted = 1'b1;
         end else begin
            if (v) begin
               if (r >= 2 && c >= 2) begin
                  exp_v[ec+3] = 1'b1;
                  exp_x[ec+3] = 9'(grad_x(r-1, c-1) >>> 2);
                  exp_y[ec+3] = 9'(grad_y(r-1, c-1) >>> 2);
                  exp_a[ec+3] = PW'((r-1)*W + (c-1));
               end
               if (n == W*H - 1) exp_fd[ec+4] = 1'b1;
               n++;
            end
            tick();
         end
      end
      bus.startEn  = noise && !aborted;
      bus.pixValid = noise;
      tick();
      bus.startEn = 1'b0;
      for (int k = 0; k < 6; k++) begin
         bus.pixValid = noise;
         bus.pixIn    = 8'($urandom_range(255));
         tick();
      end
      bus.pixValid = 1'b0;
      if (aborted) begin
         chk("abort_frameDone_count", 32'(obs_fd), 32'd0);
      end else begin
         chk("output_count",    32'(obs_outs), 32'((W-2)*(H-2)));
         chk("frameDone_count", 32'(obs_fd),   32'd1);
      end
   endtask

   initial begin
      n_cmp = 0; n_err = 0; ec = 0;
      held_x = '0; held_y = '0; held_a = '0;
      for (int k = 0; k < MAXC; k++) begin
         exp_v[k] = 1'b0; exp_fd[k] = 1'b0;
         exp_x[k] = '0;   exp_y[k] = '0; exp_a[k] = '0;
      end
      reset = 1'b1;
      bus.startEn  = 1'b0;
      bus.pixValid = 1'b0;
      bus.pixIn    = 8'd0;
      tick();
      bus.startEn  = 1'b1;
      bus.pixValid = 1'b1;
      tick();
      reset = 1'b0;
      bus.startEn  = 1'b0;
      bus.pixValid = 1'b0;
      tick();

      run_frame(0, 100, 0, -1, 1'b1);
      run_frame(1, 0, 0, -1, 1'b0);
      chk("vert_edge_x255_count", 32'(obs_x255), 32'd8);
      chk("vert_edge_y255_count", 32'(obs_y255), 32'd0);
      run_frame(2, 0, 0, -1, 1'b0);
      chk("horiz_edge_y255_count", 32'(obs_y255), 32'd12);
      chk("horiz_edge_x255_count", 32'(obs_x255), 32'd0);
      run_frame(3, 0, 30, -1, 1'b0);
      run_frame(4, 0, 0, -1, 1'b0);
      run_frame(0, 77, 0, 3*W + 5, 1'b0);
      for (int k = 0; k < 3; k++) tick();
      run_frame(0, 50, 0, -1, 1'b0);
      run_frame(3, 0, 30, -1, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
